// File: rtl/operand_skew_buffer.sv
// Operand row FIFO feeding a per-lane skew pipeline: lane i reaches the
// array edge i cycles after lane 0, forming the systolic staircase wavefront.
module operand_skew_buffer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic [LANES*WIDTH-1:0]        in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          rd_en,
    output logic [LANES*WIDTH-1:0]        data_out,
    output logic [LANES-1:0]              lane_valid,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty,
    output logic                          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [LANES*WIDTH-1:0] row_t;

    row_t              mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push;
    logic              pop;
    row_t              pop_row;
    logic [LANES-1:0]  lane_busy;

    // Flags come from the registered count only, so in_ready has no path from rd_en.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign count    = count_q;

    // NOTE: clear wins over push/pop in the same cycle, so both are masked here.
    assign push    = in_valid && in_ready && !clear;
    assign pop     = rd_en && !empty && !clear;
    assign pop_row = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: row storage is deliberately not reset; only pointers and count are,
    // and a row is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0]            v;
        logic [i:0][WIDTH-1:0] d;

        // Bubbles load zero data, so an invalid stage always carries a zero operand.
        always_ff @(posedge clk) begin
            if (clear) begin
                v <= '0;
                d <= '0;
            end else begin
                v[0] <= pop;
                d[0] <= pop ? pop_row[i*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= i; s++) begin
                    v[s] <= v[s-1];
                    d[s] <= d[s-1];
                end
            end
        end

        assign data_out[i*WIDTH +: WIDTH] = d[i];
        assign lane_valid[i]              = v[i];
        assign lane_busy[i]               = |v;
    end

    assign busy = !empty || (|lane_busy);

endmodule

// File: tb/tb_operand_skew_buffer.sv
// Randomized and directed bench for operand_skew_buffer, compared against a
// queue-based model of the FIFO and an issue-history model of the skew.
module tb_operand_skew_buffer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int RW    = LANES*WIDTH;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic [RW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          rd_en = 1'b0;
    logic [RW-1:0] data_out;
    logic [LANES-1:0] lane_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;

    operand_skew_buffer #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd_en(rd_en), .data_out(data_out),
        .lane_valid(lane_valid), .count(count), .full(full), .empty(empty),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] row;
    } issue_t;

    logic [RW-1:0] fifo_q [$];
    issue_t        hist [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [RW-1:0]    exp_data;
        logic [LANES-1:0] exp_valid;
        logic             exp_busy;
        exp_data  = '0;
        exp_valid = '0;
        exp_busy  = (fifo_q.size() != 0);
        for (int i = 0; i < LANES; i++) begin
            int idx;
            idx = hist.size() - 1 - i;
            if (idx >= 0 && hist[idx].v) begin
                exp_valid[i] = 1'b1;
                exp_data[i*WIDTH +: WIDTH] = hist[idx].row[i*WIDTH +: WIDTH];
                exp_busy = 1'b1;
            end
        end
        check("count",      64'(count),      64'(fifo_q.size()));
        check("full",       64'(full),       64'(fifo_q.size() == DEPTH));
        check("empty",      64'(empty),      64'(fifo_q.size() == 0));
        check("in_ready",   64'(in_ready),   64'(fifo_q.size() != DEPTH));
        check("lane_valid", 64'(lane_valid), 64'(exp_valid));
        check("data_out",   64'(data_out),   64'(exp_data));
        check("busy",       64'(busy),       64'(exp_busy));
    endtask

    // One clock edge: drive inputs, advance the model, then compare.
    task automatic step(input logic c, input logic v, input logic [RW-1:0] d, input logic r);
        logic   do_push;
        issue_t entry;
        clear    = c;
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        do_push = !c && v && (fifo_q.size() < DEPTH);
        entry   = '0;
        if (!c && r && fifo_q.size() > 0) entry = '{v: 1'b1, row: fifo_q[0]};
        @(posedge clk);
        #1;
        if (c) begin
            fifo_q.delete();
            foreach (hist[j]) hist[j] = '0;
        end else begin
            if (entry.v) void'(fifo_q.pop_front());
            if (do_push) fifo_q.push_back(d);
        end
        hist.push_back(entry);
        if (hist.size() > LANES) void'(hist.pop_front());
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Reset for two cycles, then explicit reset values.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        check("rst_data_out", 64'(data_out),   64'h0);
        check("rst_valid",    64'(lane_valid), 64'h0);
        check("rst_count",    64'(count),      64'h0);
        check("rst_empty",    64'(empty),      64'h1);
        check("rst_full",     64'(full),       64'h0);
        check("rst_in_ready", 64'(in_ready),   64'h1);
        check("rst_busy",     64'(busy),       64'h0);

        // Single row: staircase on lanes 0..3, busy drops after the fourth lane.
        step(1'b0, 1'b1, 32'h04030201, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("sr_lane0", 64'(data_out), 64'h00000001);
        step(1'b0, 1'b0, '0, 1'b0);
        check("sr_lane1", 64'(data_out), 64'h00000200);
        step(1'b0, 1'b0, '0, 1'b0);
        check("sr_lane2", 64'(data_out), 64'h00030000);
        step(1'b0, 1'b0, '0, 1'b0);
        check("sr_lane3", 64'(data_out), 64'h04000000);
        check("sr_busy_hi", 64'(busy), 64'h1);
        step(1'b0, 1'b0, '0, 1'b0);
        check("sr_busy_lo", 64'(busy), 64'h0);

        // Fill and backpressure, then one pop releases space for the fifth row.
        step(1'b0, 1'b1, 32'h11111111, 1'b0);
        step(1'b0, 1'b1, 32'h22222222, 1'b0);
        step(1'b0, 1'b1, 32'h33333333, 1'b0);
        step(1'b0, 1'b1, 32'h44444444, 1'b0);
        step(1'b0, 1'b1, 32'h55555555, 1'b0);
        check("bp_full",  64'(full),     64'h1);
        check("bp_ready", 64'(in_ready), 64'h0);
        step(1'b0, 1'b1, 32'h55555555, 1'b1);
        check("bp_ready_after_pop", 64'(in_ready), 64'h1);
        step(1'b0, 1'b1, 32'h55555555, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1);
        idle(LANES);

        // Simultaneous push/pop at count=2, wrapping the pointers.
        step(1'b0, 1'b1, 32'hA0A0A0A0, 1'b0);
        step(1'b0, 1'b1, 32'hA1A1A1A1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, {4{8'(8'hB0 + k)}}, 1'b1);
            check("pp_count", 64'(count), 64'h2);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(LANES);

        // Empty read injects a bubble and does not underflow.
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("er_count", 64'(count), 64'h0);
        idle(LANES);

        // Clear one edge after a pop discards the in-flight row.
        step(1'b0, 1'b1, 32'hAABBCCDD, 1'b0);
        step(1'b0, 1'b1, 32'h12345678, 1'b1);
        step(1'b1, 1'b1, 32'h87654321, 1'b1);
        check("cl_valid", 64'(lane_valid), 64'h0);
        check("cl_data",  64'(data_out),   64'h0);
        check("cl_count", 64'(count),      64'h0);
        idle(LANES);

        // Random traffic with occasional clears.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
                 RW'($urandom), ($urandom_range(0, 1) == 1));
        end
        idle(LANES + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
